// File: rtl/wishbone_vga_initiator.sv
// wishbone_vga_initiator: valid/ready command stream to single-beat Wishbone classic master with timeout
module wishbone_vga_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic [7:0]  err_count,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [31:0] adr,
  output logic [31:0] dat,
  output logic [3:0]  sel,
  input  logic [31:0] din,
  input  logic        ack
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic cmd_ready_n, rsp_valid_n, rsp_err_n, cyc_n, stb_n, we_n;
  logic [31:0] rsp_dat_n, adr_n, dat_n;
  logic [3:0] sel_n;
  logic [7:0] err_count_n;
  // next-state and next-output logic; every output is registered below
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cmd_ready_n = cmd_ready;
    rsp_valid_n = rsp_valid;
    rsp_err_n = rsp_err;
    rsp_dat_n = rsp_dat;
    err_count_n = err_count;
    cyc_n = cyc;
    stb_n = stb;
    we_n = we;
    adr_n = adr;
    dat_n = dat;
    sel_n = sel;
    case (state)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_n = 1'b0;
          cyc_n = 1'b1;
          stb_n = 1'b1;
          we_n = cmd_we;
          adr_n = cmd_adr;
          dat_n = cmd_dat;
          sel_n = cmd_sel;
          cnt_n = '0;
          state_n = BUS;
        end
      end
      BUS: begin
        cnt_n = cnt + 1'b1;
        if (ack || cnt == LAST) begin
          cyc_n = 1'b0;
          stb_n = 1'b0;
          we_n = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n = !ack;
          rsp_dat_n = (ack && !we) ? din : 32'd0;
          err_count_n = (ack || &err_count) ? err_count : err_count + 8'd1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // state and output registers; reset drops the bus and discards any pending response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_dat <= '0;
      err_count <= '0;
      cyc <= 1'b0;
      stb <= 1'b0;
      we <= 1'b0;
      adr <= '0;
      dat <= '0;
      sel <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cmd_ready <= cmd_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_err <= rsp_err_n;
      rsp_dat <= rsp_dat_n;
      err_count <= err_count_n;
      cyc <= cyc_n;
      stb <= stb_n;
      we <= we_n;
      adr <= adr_n;
      dat <= dat_n;
      sel <= sel_n;
    end
  end
endmodule

// File: doc/wishbone_vga_initiator.md
# wishbone_vga_initiator

Wishbone classic initiator that drives the slave port of the VGA controller (and any other classic Wishbone responder) from a simple valid/ready command stream. It issues one single-beat read or write per command, holds the bus until `ack` or a timeout, and returns one response per command on a valid/ready response channel. It sits between a local sequencer or test harness and the VGA controller register bus, so the controller can be programmed without the management SoC.

## Interface

Parameters:
- `TIMEOUT`, default 255: maximum cycles `cyc`/`stb` stay asserted without `ack`. Legal range is ≥1.

Ports:
- `clk`  in  1  the single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_adr`  in  32  byte address.
- `cmd_dat`  in  32  write data.
- `cmd_sel`  in  4  byte selects.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_dat`  out  32  read data. It is 0 for writes and on error.
- `rsp_err`  out  1  1 = timeout, no `ack` received.
- `err_count`  out  8  number of timeouts; saturates at 255.
- `cyc`, `stb`, `we`  out  1 each  Wishbone cycle, strobe and write-enable.
- `adr`  out  32  Wishbone address.
- `dat`  out  32  Wishbone write data, to the slave's `dat`.
- `sel`  out  4  Wishbone byte selects.
- `din`  in  32  Wishbone read data, from the slave's `dout`.
- `ack`  in  1  Wishbone acknowledge.

## Operation

- FSM states are IDLE, BUS and RESP. All outputs are registered.
- **IDLE:**
  - `cmd_ready`=1.
  - When `cmd_valid`&`cmd_ready`, the block latches `cmd_we/adr/dat/sel` into `we/adr/dat/sel`, sets `cyc`=`stb`=1, clears the timeout counter and moves to BUS.
- **BUS:**
  - `cmd_ready`=0. `cyc`, `stb`, `we`, `adr`, `dat` and `sel` are held stable.
  - The timeout counter increments every cycle. Its width is $clog2(TIMEOUT+1).
  - If `ack` is sampled high:
    - `cyc`, `stb` and `we` go to 0.
    - `rsp_dat` = `din` if a read, else 0.
    - `rsp_err`=0, `rsp_valid`=1, go to RESP.
  - Otherwise, if the counter equals TIMEOUT-1:
    - `cyc`, `stb` and `we` go to 0.
    - `rsp_dat`=0, `rsp_err`=1, `rsp_valid`=1.
    - `err_count` increments unless it is already 255.
    - Go to RESP.
  - If `ack` and the timeout fall in the same cycle, `ack` wins and there is no error.
- **RESP:**
  - `rsp_valid`, `rsp_dat` and `rsp_err` are held until `rsp_ready`=1.
  - On that handshake: `rsp_valid`=0, `cmd_ready`=1, go to IDLE.
- `ack` outside BUS is ignored; no state or counter changes.
- `adr`, `dat` and `sel` keep their last values after the cycle ends. `we` returns to 0.
- Exactly one response is produced per accepted command, and commands are strictly in order.

## Timing

- **Reset values:** `cyc`=`stb`=`we`=0, `adr`=`dat`=0, `sel`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_dat`=0, `err_count`=0, `cmd_ready`=0, state IDLE.
- **After reset release:** `cmd_ready` rises on the first `clk` edge.
- **Reset mid-operation:** `cyc`/`stb` drop asynchronously and any pending response is discarded.
- **Command to bus:** the command is accepted at edge N and `cyc`/`stb` are high from edge N.
- **Bus to response:**
  - `ack` sampled at edge M: `cyc` is low and `rsp_valid` is high from edge M.
  - A zero-wait slave therefore sees a bus cycle exactly one clock long.
- **Timeout:** `cyc` is high for exactly TIMEOUT cycles. With TIMEOUT=1 it is one cycle and an error results unless `ack` arrives in that cycle.
- **Response handshake:** `rsp_ready` at edge R gives `rsp_valid`=0 and `cmd_ready`=1 from R. The next command can be accepted at R+1.
- **Throughput:** at best one transaction per 3 cycles.
- **`rsp_ready` held high:** RESP still lasts exactly one cycle.
- **`cmd_valid` during BUS/RESP:** no effect, because `cmd_ready`=0. The command is taken on return to IDLE.

## Test plan

- **Reset:** assert `rst` mid-BUS with `cyc`=1.
  - `cyc`/`stb`/`rsp_valid` are 0 with no clock edge.
  - After release, `cmd_ready`=1 on the next edge and `err_count`=0.
- **Write, zero-wait slave:** `cmd_we`=1, `adr`=0x30000004, `dat`=0x0000_0280, `sel`=0xF, `ack` the cycle after `cyc` rises.
  - `cyc` is high exactly 1 cycle with `we`=1.
  - Response: `rsp_valid`=1, `rsp_err`=0, `rsp_dat`=0.
- **Read, 5 wait states:** `din`=0xDEADBEEF on `ack`.
  - `cyc` is high 6 cycles.
  - Response: `rsp_dat`=0xDEADBEEF, `rsp_err`=0.
- **Timeout:** TIMEOUT=4, `ack` never asserted.
  - `cyc` is high exactly 4 cycles.
  - Response: `rsp_err`=1, `rsp_dat`=0, `err_count`=1.
  - Repeat 300 times: `err_count` saturates at 255.
- **Ack on the timeout cycle:** TIMEOUT=4, `ack` in the 4th cycle.
  - `rsp_err`=0 and `err_count` is unchanged.
- **Backpressure and stray ack:**
  - Hold `rsp_ready`=0 for 10 cycles: the response is held stable and `cmd_ready`=0.
  - Pulse `ack` during RESP/IDLE: no state change.
  - Then `rsp_ready`=1 with back-to-back commands: strict in-order responses, with the next `cyc` starting at R+1.
